// File: rtl/bus_pkg.sv
// Shared bus source map and scheduler types for the 32-bit datapath bus.
package bus_pkg;

    localparam int N_SRC = 24;
    localparam int IDX_W = 5;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_C      = 23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RECOVER = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after the start pointer, wrapping.
module rr_picker #(
    parameter int N_SRC = 24,
    parameter int IDX_W = 5
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [2*N_SRC-1:0] req_dbl;

    assign req_dbl = {req, req};

    // Scanning downward lets the lowest qualifying position overwrite all others;
    // the upper copy of req covers the wrap from the last source back to 0.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 2*N_SRC-1; i >= 0; i--) begin
            if (req_dbl[i] && (i >= int'(start))) begin
                winner = IDX_W'(i % N_SRC);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_scheduler.sv
// Round-robin bus arbiter with bounded hold time and a one-cycle turnaround between owners.
module bus_scheduler #(
    parameter int N_SRC    = bus_pkg::N_SRC,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] grant,
    output logic [4:0]       grant_idx,
    output logic             bus_busy,
    output logic             preempt
);
    import bus_pkg::*;

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             preempt_q, preempt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             owner_req;

    rr_picker #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .start  (ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign owner_req = req[owner_q];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    hold_d  = CNT_W'(1);
                    state_d = OWNED;
                end
            end
            OWNED: begin
                // A release always wins over expiry, so preempt only fires for a live request.
                if (!owner_req) begin
                    hold_d  = '0;
                    state_d = RECOVER;
                end else if (hold_q < CNT_W'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d    = '0;
                    preempt_d = 1'b1;
                    state_d   = RECOVER;
                end
            end
            RECOVER: begin
                ptr_d   = (owner_q == IDX_W'(N_SRC - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus_busy  = (state_q == OWNED);
    assign grant     = bus_busy ? (N_SRC'(1) << owner_q) : '0;
    assign grant_idx = bus_busy ? owner_q : '0;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: directed scenarios plus random traffic against a tenure-level model.
module tb_bus_scheduler;

    localparam int NS       = 24;
    localparam int MAX_HOLD = 4;

    logic          clk;
    logic          clr;
    logic [NS-1:0] req;
    logic [NS-1:0] grant;
    logic [4:0]    grant_idx;
    logic          bus_busy;
    logic          preempt;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus, how long they have held it, turnaround cycles left, next search start.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_next  = 0;
    int m_pre   = 0;

    int seen_owners[$];
    int preempt_seen = 0;
    logic prev_busy = 1'b0;

    bus_scheduler #(
        .N_SRC    (NS),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .bus_busy  (bus_busy),
        .preempt   (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int rrSearch(input logic [NS-1:0] r, input int start);
        for (int k = 0; k < NS; k++) begin
            if (r[(start + k) % NS]) return (start + k) % NS;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic [NS-1:0] r, input logic c);
        m_pre = 0;
        if (!c) begin
            m_owner = -1;
            m_held  = 0;
            m_gap   = 0;
            m_next  = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner] || m_held == MAX_HOLD) begin
                m_pre   = r[m_owner] ? 1 : 0;
                m_next  = (m_owner + 1) % NS;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            m_owner = rrSearch(r, m_next);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end
    endtask

    task automatic compareAll();
        logic [NS-1:0] exp_grant;
        exp_grant = (m_owner >= 0) ? (24'd1 << m_owner) : 24'd0;
        checkOutput("grant", 32'(grant), 32'(exp_grant));
        checkOutput("grant_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        checkOutput("bus_busy", 32'(bus_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        checkOutput("preempt", 32'(preempt), 32'(m_pre));
        checkOutput("inv_onehot0", 32'($onehot0(grant)), 32'd1);
        checkOutput("inv_busy", 32'(bus_busy), 32'(|grant));
        checkOutput("inv_idx", 32'(grant), bus_busy ? 32'(24'd1 << grant_idx) : 32'd0);
    endtask

    task automatic applyStimulus(input logic [NS-1:0] r, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            req = r;
            clr = c;
            @(posedge clk);
            modelStep(r, c);
            #1;
            compareAll();
            if (bus_busy && !prev_busy) seen_owners.push_back(int'(grant_idx));
            if (preempt) preempt_seen++;
            prev_busy = bus_busy;
        end
    endtask

    initial begin
        logic [NS-1:0] rnd_req;
        logic          rnd_clr;
        int            exp_rr[4];

        req = '0;
        clr = 1'b0;
        @(negedge clk);

        // Reset with every source requesting, then the first grant must go to R0.
        applyStimulus(24'hFFFFFF, 1'b0, 2);
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_idx", 32'(grant_idx), 32'd0);
        applyStimulus(24'hFFFFFF, 1'b1, 1);
        checkOutput("first_grant", 32'(grant), 32'd1);
        applyStimulus(24'h000000, 1'b1, 3);

        // Three persistent requesters rotate with a forced handoff after each full tenure.
        seen_owners.delete();
        preempt_seen = 0;
        applyStimulus((24'd1 << 3) | (24'd1 << 5) | (24'd1 << 20), 1'b1, 20);
        exp_rr = '{3, 5, 20, 3};
        checkOutput("rr_count", 32'(seen_owners.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_owners.size(); i++) begin
            checkOutput($sformatf("rr_owner%0d", i), 32'(seen_owners[i]), 32'(exp_rr[i]));
        end
        checkOutput("rr_preempts", 32'(preempt_seen), 32'd3);
        applyStimulus(24'h000000, 1'b1, 3);

        // MDR releases early: no preempt.
        preempt_seen = 0;
        applyStimulus(24'd1 << 21, 1'b1, 2);
        checkOutput("mdr_idx", 32'(grant_idx), 32'd21);
        applyStimulus(24'h000000, 1'b1, 3);
        checkOutput("mdr_preempt", 32'(preempt_seen), 32'd0);

        // Source 23 keeps the bus while R0 asks; R0 follows after the turnaround.
        applyStimulus(24'd1 << 23, 1'b1, 1);
        applyStimulus((24'd1 << 23) | 24'd1, 1'b1, 2);
        checkOutput("wrap_hold", 32'(grant_idx), 32'd23);
        applyStimulus(24'd1, 1'b1, 2);
        checkOutput("wrap_gap", 32'(grant), 32'd0);
        applyStimulus(24'd1, 1'b1, 1);
        checkOutput("wrap_grant", 32'(grant), 32'd1);
        applyStimulus(24'h000000, 1'b1, 3);

        // Owner 7 drops req exactly when its tenure would expire.
        applyStimulus(24'd1 << 7, 1'b1, 4);
        applyStimulus(24'h000000, 1'b1, 1);
        checkOutput("simul_preempt", 32'(preempt), 32'd0);
        checkOutput("simul_grant", 32'(grant), 32'd0);
        applyStimulus(24'h000000, 1'b1, 2);

        // Reset during ownership restarts the search at R0.
        applyStimulus(24'd1 << 12, 1'b1, 2);
        checkOutput("mid_owner", 32'(grant_idx), 32'd12);
        applyStimulus(24'd1 << 12, 1'b0, 1);
        checkOutput("mid_reset_grant", 32'(grant), 32'd0);
        checkOutput("mid_reset_preempt", 32'(preempt), 32'd0);
        applyStimulus((24'd1 << 12) | (24'd1 << 2), 1'b1, 1);
        checkOutput("mid_winner", 32'(grant_idx), 32'd2);
        applyStimulus(24'h000000, 1'b1, 3);

        // Random traffic with requests that persist for a while and rare resets.
        rnd_req = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = NS'($urandom & $urandom);
            rnd_clr = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            applyStimulus(rnd_req, rnd_clr, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
